// File: rtl/ysyx_23060124_lsu_sram_pkg.sv
// Shared definitions for the LSU data-memory responder.
// Provides the access-length codes, the responder FSM state type and
// helpers that turn an access length into byte-lane and bit-lane masks.
package ysyx_23060124_lsu_sram_pkg;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Byte enables for an access of the given length at lane 0.
  function automatic logic [3:0] len_mask(input logic [2:0] len);
    logic [3:0] m;
    case (len)
      LEN_B:   m = MASK_B;
      LEN_H:   m = MASK_H;
      LEN_W:   m = MASK_W;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Expands a byte-lane mask into a 32-bit bit mask.
  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    logic [31:0] bits;
    for (int b = 0; b < 4; b++) begin
      bits[8*b +: 8] = {8{m[b]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/ysyx_23060124_sram_bank.sv
// Single-port synchronous word array with per-byte write enables.
// Ports:
//   clk   - clock, rising edge
//   addr  - word index
//   we    - write strobe, qualified by be
//   be    - byte-lane write enables
//   wdata - write data, already lane-aligned
//   rdata - registered read of addr (old data when writing the same word)
// The array is intentionally not reset.
module ysyx_23060124_sram_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ysyx_23060124_lsu_sram.sv
// Data-memory responder on the slave side of the LSU load/store interface.
// Accepts one request at a time, waits a fixed latency, performs the access
// against a little-endian word array and returns data or an acknowledge.
// Ports:
//   clk, rst_n             - clock and asynchronous active-low reset
//   req_valid/req_ready    - request handshake
//   req_addr/wen/len/wdata - byte address, store flag, size (1/2/4), store data
//   resp_valid/resp_ready  - response handshake
//   resp_rdata/resp_err    - right-justified load data, access error flag
module ysyx_23060124_lsu_sram
  import ysyx_23060124_lsu_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [2:0]  req_len,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic [31:0] SPAN    = 32'(DEPTH * 4);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic        lat_wen;
  logic [2:0]  lat_len;
  logic [31:0] lat_wdata;

  logic [31:0] lat_off;
  logic [1:0]  byte_ofs;
  logic        acc_err;
  logic        bank_we;
  logic [3:0]  bank_be;
  logic [31:0] bank_wdata;
  logic [31:0] bank_rdata;
  logic [31:0] load_data;

  // The unsigned subtraction makes addresses below the base wrap to huge
  // offsets, so a single compare catches both ends of the window.
  assign lat_off  = lat_addr - BASE_ADDR;
  assign byte_ofs = lat_addr[1:0];

  always_comb begin
    acc_err = (lat_off >= SPAN);
    case (lat_len)
      LEN_B:   ;
      LEN_H:   if (lat_addr[0]) acc_err = 1'b1;
      LEN_W:   if (lat_addr[1:0] != 2'b00) acc_err = 1'b1;
      default: acc_err = 1'b1;
    endcase
  end

  assign bank_we    = (state == ST_EXEC) && lat_wen && !acc_err;
  assign bank_be    = len_mask(lat_len) << byte_ofs;
  assign bank_wdata = lat_wdata << {byte_ofs, 3'b000};
  assign load_data  = (bank_rdata >> {byte_ofs, 3'b000}) & lane_bits(len_mask(lat_len));

  // The bank always reads the latched address; since WAIT lasts at least
  // one cycle, the word is already on bank_rdata throughout EXEC.
  ysyx_23060124_sram_bank #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_bank (
    .clk  (clk),
    .addr (lat_off[AW+1:2]),
    .we   (bank_we),
    .be   (bank_be),
    .wdata(bank_wdata),
    .rdata(bank_rdata)
  );

  // Every request passes through WAIT, even at LATENCY==1 where the counter
  // starts at 0, so the response always appears LATENCY+1 edges after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      lat_addr   <= 32'd0;
      lat_wen    <= 1'b0;
      lat_len    <= 3'd0;
      lat_wdata  <= 32'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_addr  <= req_addr;
            lat_wen   <= req_wen;
            lat_len   <= req_len;
            lat_wdata <= req_wdata;
            cnt       <= CNT_INIT;
            req_ready <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_EXEC;
          else             cnt   <= cnt - 4'd1;
        end
        ST_EXEC: begin
          resp_valid <= 1'b1;
          resp_err   <= acc_err;
          resp_rdata <= (acc_err || lat_wen) ? 32'd0 : load_data;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
